// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared constants, state enum and PC helpers for the instruction dequeue stage
package dispatch_pkg;

  localparam int SLOTS     = 4;
  localparam int ENTRY_W   = 64;
  localparam int INSTR_LSB = 0;
  localparam int INSTR_W   = 32;
  localparam int PC_LSB    = 32;
  localparam int PC_W      = 32;
  localparam int CNT_W     = 3;

  // Queue entries carry PC+4; the dispatched PC is the entry's own address.
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_POP   = 2'd2,
    ST_FLUSH = 2'd3
  } deq_state_e;

  function automatic logic [PC_W-1:0] entry_pc(input logic [ENTRY_W-1:0] entry);
    return entry[PC_LSB +: PC_W] - PC_STEP;
  endfunction

  function automatic logic [INSTR_W-1:0] entry_instr(input logic [ENTRY_W-1:0] entry);
    return entry[INSTR_LSB +: INSTR_W];
  endfunction

endpackage

// File: rtl/instr_slot_count.sv
// rtl/instr_slot_count.sv - contiguous non-empty head count and lane mask from the queue empty flags
module instr_slot_count
  import dispatch_pkg::*;
(
  input  logic [SLOTS-1:0] i_empty,
  output logic [CNT_W-1:0] o_count,
  output logic [SLOTS-1:0] o_mask
);

  logic w_run;

  // Count leading non-empty slots; an unknown empty flag fails the ==0 test and ends the run.
  always_comb begin
    o_count = '0;
    o_mask  = '0;
    w_run   = 1'b1;
    for (int k = 0; k < SLOTS; k++) begin
      if (w_run && (i_empty[k] == 1'b0)) begin
        o_count   = o_count + CNT_W'(1);
        o_mask[k] = 1'b1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/instr_dequeue.sv
// rtl/instr_dequeue.sv - pops up to four queue heads into a held dispatch bundle; INSTR_DEQUEUE_STATS_EN adds stall/dispatch counters
module instr_dequeue
  import dispatch_pkg::*;
#(
  parameter int SLOTS = dispatch_pkg::SLOTS
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [63:0] InstrQueueBufOut0,
  input  logic [63:0] InstrQueueBufOut1,
  input  logic [63:0] InstrQueueBufOut2,
  input  logic [63:0] InstrQueueBufOut3,
  input  logic        InstrQueueBufEmpty0,
  input  logic        InstrQueueBufEmpty1,
  input  logic        InstrQueueBufEmpty2,
  input  logic        InstrQueueBufEmpty3,
  input  logic        Flush,
  output logic [1:0]  InstrQueueRE,
  output logic        InstrQueueRCLK,
  output logic        DecValid,
  input  logic        DecReady,
  output logic [3:0]  DecSlotValid,
  output logic [31:0] DecInstr0,
  output logic [31:0] DecInstr1,
  output logic [31:0] DecInstr2,
  output logic [31:0] DecInstr3,
  output logic [31:0] DecPC0,
  output logic [31:0] DecPC1,
  output logic [31:0] DecPC2,
  output logic [31:0] DecPC3
`ifdef INSTR_DEQUEUE_STATS_EN
  ,
  output logic [31:0] StallCycles,
  output logic [31:0] DispatchCount
`endif
);

  logic [ENTRY_W-1:0] w_head [SLOTS];
  logic [SLOTS-1:0]   w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [SLOTS-1:0]   w_mask;
  logic               w_capture;
  logic               w_dispatch;

  deq_state_e         r_state;
  logic               r_valid;
  logic [SLOTS-1:0]   r_slot_valid;
  logic [1:0]         r_re;
  logic               r_rclk;
  logic [INSTR_W-1:0] r_instr [SLOTS];
  logic [PC_W-1:0]    r_pc    [SLOTS];

  assign w_head[0] = InstrQueueBufOut0;
  assign w_head[1] = InstrQueueBufOut1;
  assign w_head[2] = InstrQueueBufOut2;
  assign w_head[3] = InstrQueueBufOut3;
  assign w_empty   = {InstrQueueBufEmpty3, InstrQueueBufEmpty2,
                      InstrQueueBufEmpty1, InstrQueueBufEmpty0};

  instr_slot_count u_slot_count (
    .i_empty (w_empty),
    .o_count (w_count),
    .o_mask  (w_mask)
  );

  // A new bundle is taken only when nothing is held or the held one is leaving this cycle.
  assign w_capture = ((r_state == ST_EMPTY) || ((r_state == ST_HOLD) && DecReady)) &&
                     (w_count != '0) && !r_rclk && !Flush;

  // The handshake is honoured only in HOLD; the POP cycle is the mandatory pop strobe slot.
  assign w_dispatch = (r_state == ST_HOLD) && DecReady && !Flush;

  // Dequeue FSM with all dispatch and queue-control outputs registered.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state      <= ST_EMPTY;
      r_valid      <= 1'b0;
      r_slot_valid <= '0;
      r_re         <= '0;
      r_rclk       <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        r_instr[k] <= '0;
        r_pc[k]    <= '0;
      end
    end else if (Flush) begin
      r_state      <= ST_FLUSH;
      r_valid      <= 1'b0;
      r_slot_valid <= '0;
      r_rclk       <= 1'b0;
    end else if (w_capture) begin
      r_state      <= ST_POP;
      r_valid      <= 1'b1;
      r_slot_valid <= w_mask;
      r_re         <= w_count[1:0] - 2'd1;
      r_rclk       <= 1'b1;
      for (int k = 0; k < SLOTS; k++) begin
        if (w_mask[k]) begin
          r_instr[k] <= entry_instr(w_head[k]);
          r_pc[k]    <= entry_pc(w_head[k]);
        end else begin
          r_instr[k] <= '0;
          r_pc[k]    <= '0;
        end
      end
    end else begin
      case (r_state)
        ST_POP: begin
          r_rclk  <= 1'b0;
          r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (DecReady) begin
            r_state      <= ST_EMPTY;
            r_valid      <= 1'b0;
            r_slot_valid <= '0;
          end
        end
        ST_FLUSH: r_state <= ST_EMPTY;
        default:  r_state <= ST_EMPTY;
      endcase
    end
  end

  assign InstrQueueRE   = r_re;
  assign InstrQueueRCLK = r_rclk;
  assign DecValid       = r_valid;
  assign DecSlotValid   = r_slot_valid;
  assign DecInstr0      = r_instr[0];
  assign DecInstr1      = r_instr[1];
  assign DecInstr2      = r_instr[2];
  assign DecInstr3      = r_instr[3];
  assign DecPC0         = r_pc[0];
  assign DecPC1         = r_pc[1];
  assign DecPC2         = r_pc[2];
  assign DecPC3         = r_pc[3];

`ifdef INSTR_DEQUEUE_STATS_EN
  logic [31:0] r_stall;
  logic [31:0] r_disp;
  logic [32:0] w_disp_sum;

  assign w_disp_sum = {1'b0, r_disp} + 33'($countones(r_slot_valid));

  // Saturating stall and dispatched-instruction counters.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_stall <= '0;
      r_disp  <= '0;
    end else begin
      if (r_valid && !DecReady && (r_stall != '1)) begin
        r_stall <= r_stall + 32'd1;
      end
      if (w_dispatch) begin
        r_disp <= w_disp_sum[32] ? '1 : w_disp_sum[31:0];
      end
    end
  end

  assign StallCycles   = r_stall;
  assign DispatchCount = r_disp;
`else
  // Counters are not built; timing of the dispatch path is unchanged.
`endif

endmodule

// File: tb/tb_instr_dequeue.sv
// tb/tb_instr_dequeue.sv - randomized and directed self-checking bench for instr_dequeue
module tb_instr_dequeue;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [63:0] bo [4];
  logic [3:0]  emp;
  logic        Flush;
  logic        DecReady;
  logic [1:0]  InstrQueueRE;
  logic        InstrQueueRCLK;
  logic        DecValid;
  logic [3:0]  DecSlotValid;
  logic [31:0] d_instr [4];
  logic [31:0] d_pc [4];
`ifdef INSTR_DEQUEUE_STATS_EN
  logic [31:0] StallCycles;
  logic [31:0] DispatchCount;
`endif

  always #5 CLK = ~CLK;

  instr_dequeue dut (
    .CLK                 (CLK),
    .Reset               (Reset),
    .InstrQueueBufOut0   (bo[0]),
    .InstrQueueBufOut1   (bo[1]),
    .InstrQueueBufOut2   (bo[2]),
    .InstrQueueBufOut3   (bo[3]),
    .InstrQueueBufEmpty0 (emp[0]),
    .InstrQueueBufEmpty1 (emp[1]),
    .InstrQueueBufEmpty2 (emp[2]),
    .InstrQueueBufEmpty3 (emp[3]),
    .Flush               (Flush),
    .InstrQueueRE        (InstrQueueRE),
    .InstrQueueRCLK      (InstrQueueRCLK),
    .DecValid            (DecValid),
    .DecReady            (DecReady),
    .DecSlotValid        (DecSlotValid),
    .DecInstr0           (d_instr[0]),
    .DecInstr1           (d_instr[1]),
    .DecInstr2           (d_instr[2]),
    .DecInstr3           (d_instr[3]),
    .DecPC0              (d_pc[0]),
    .DecPC1              (d_pc[1]),
    .DecPC2              (d_pc[2]),
    .DecPC3              (d_pc[3])
`ifdef INSTR_DEQUEUE_STATS_EN
    ,
    .StallCycles         (StallCycles),
    .DispatchCount       (DispatchCount)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: what the decode side must see, derived from the bundle rules.
  logic        m_valid;
  logic [3:0]  m_slotv;
  logic [1:0]  m_re;
  logic        m_rclk;
  logic        m_flushing;
  logic [31:0] m_instr [4];
  logic [31:0] m_pc [4];
  logic [31:0] m_stall;
  logic [31:0] m_disp;

  task automatic model_clear();
    m_valid = 0; m_slotv = 0; m_re = 0; m_rclk = 0; m_flushing = 0;
    m_stall = 0; m_disp = 0;
    for (int k = 0; k < 4; k++) begin
      m_instr[k] = 0;
      m_pc[k]    = 0;
    end
  endtask

  task automatic model_step();
    int n;
    logic [32:0] sum;
    n = 0;
    while (n < 4 && !emp[n]) n++;
    if (m_valid && !DecReady && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (m_valid && !m_rclk && DecReady && !Flush) begin
      sum = {1'b0, m_disp} + 33'($countones(m_slotv));
      m_disp = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    end
    if (Flush) begin
      m_valid = 0; m_slotv = 0; m_rclk = 0; m_flushing = 1;
    end else if (m_flushing) begin
      m_flushing = 0;
    end else if (m_rclk) begin
      m_rclk = 0;
    end else if (!m_valid || DecReady) begin
      if (n > 0) begin
        m_valid = 1;
        m_slotv = 4'((1 << n) - 1);
        m_re    = 2'(n - 1);
        m_rclk  = 1;
        for (int k = 0; k < 4; k++) begin
          m_instr[k] = (k < n) ? bo[k][31:0] : 32'h0;
          m_pc[k]    = (k < n) ? (bo[k][63:32] - 32'd4) : 32'h0;
        end
      end else begin
        m_valid = 0;
        m_slotv = 0;
      end
    end
  endtask

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) model_clear();
    else        model_step();
  end

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge CLK) begin
    if (Reset) begin
      chk("valid", 32'(DecValid), 32'(m_valid));
      chk("slot_valid", 32'(DecSlotValid), 32'(m_slotv));
      chk("rclk", 32'(InstrQueueRCLK), 32'(m_rclk));
      chk("re", 32'(InstrQueueRE), 32'(m_re));
      for (int k = 0; k < 4; k++) begin
        if (m_valid && m_slotv[k]) begin
          chk($sformatf("instr%0d", k), d_instr[k], m_instr[k]);
          chk($sformatf("pc%0d", k), d_pc[k], m_pc[k]);
        end
      end
`ifdef INSTR_DEQUEUE_STATS_EN
      chk("stall_cycles", StallCycles, m_stall);
      chk("dispatch_count", DispatchCount, m_disp);
`endif
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    Reset = 0; emp = 4'hF; Flush = 0; DecReady = 1;
    for (int k = 0; k < 4; k++) bo[k] = 64'h0;
    #12;
    chk("rst_valid", 32'(DecValid), 32'h0);
    chk("rst_slotv", 32'(DecSlotValid), 32'h0);
    chk("rst_re", 32'(InstrQueueRE), 32'h0);
    chk("rst_rclk", 32'(InstrQueueRCLK), 32'h0);
    chk("rst_pc0", d_pc[0], 32'h0);
    chk("rst_instr3", d_instr[3], 32'h0);
    @(posedge CLK); #2;
    Reset = 1;
    step();

    // Full four-wide capture
    for (int k = 0; k < 4; k++) bo[k] = {32'h104 + 32'(4 * k), 32'hA000_0000 + 32'(k)};
    emp = 4'h0;
    step();
    chk("full_re", 32'(InstrQueueRE), 32'd3);
    chk("full_rclk", 32'(InstrQueueRCLK), 32'd1);
    chk("full_slotv", 32'(DecSlotValid), 32'hF);
    chk("full_pc0", d_pc[0], 32'h100);
    chk("full_pc3", d_pc[3], 32'h10C);
    emp = 4'hF;
    step();
    chk("full_rclk_drop", 32'(InstrQueueRCLK), 32'd0);
    chk("full_valid_pop", 32'(DecValid), 32'd1);
    step();
    chk("full_done_valid", 32'(DecValid), 32'd0);
    chk("full_done_rclk", 32'(InstrQueueRCLK), 32'd0);

    // Gap at slot 1 limits the bundle to one lane
    bo[0] = {32'h200, 32'hB000_0000};
    emp = 4'b1010;
    step();
    chk("gap_re", 32'(InstrQueueRE), 32'd0);
    chk("gap_slotv", 32'(DecSlotValid), 32'b0001);
    chk("gap_pc0", d_pc[0], 32'h1FC);
    step();

    // Five stalled cycles with a bundle held
    DecReady = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(DecValid), 32'd1);
      chk("stall_rclk", 32'(InstrQueueRCLK), 32'd0);
      chk("stall_pc0", d_pc[0], 32'h1FC);
      chk("stall_slotv", 32'(DecSlotValid), 32'b0001);
    end
`ifdef INSTR_DEQUEUE_STATS_EN
    chk("stall_count5", StallCycles, 32'd5);
`endif
    DecReady = 1;
    step();
    step();

    // One-cycle flush while held and ready
    Flush = 1;
    for (int k = 0; k < 4; k++) bo[k] = {32'h300 + 32'(4 * k), 32'hC000_0000 + 32'(k)};
    emp = 4'h0;
    step();
    chk("flush_valid1", 32'(DecValid), 32'd0);
    chk("flush_slotv", 32'(DecSlotValid), 32'd0);
    chk("flush_rclk", 32'(InstrQueueRCLK), 32'd0);
    Flush = 0;
    step();
    chk("flush_valid2", 32'(DecValid), 32'd0);
    step();
    chk("flush_recap_valid", 32'(DecValid), 32'd1);
    chk("flush_recap_pc0", d_pc[0], 32'h2FC);
    chk("flush_recap_rclk", 32'(InstrQueueRCLK), 32'd1);
`ifdef INSTR_DEQUEUE_STATS_EN
    chk("flush_disp_count", DispatchCount, 32'd5);
`endif

    // Reset during the pop strobe
    Reset = 0;
    #1;
    chk("rstpop_rclk", 32'(InstrQueueRCLK), 32'd0);
    chk("rstpop_valid", 32'(DecValid), 32'd0);
    emp = 4'hF;
    step();
    Reset = 1;
    step();
    chk("rstpop_idle_valid", 32'(DecValid), 32'd0);
    chk("rstpop_idle_rclk", 32'(InstrQueueRCLK), 32'd0);
    bo[0] = {32'h404, 32'hD000_0000};
    emp = 4'b1110;
    step();
    chk("rstpop_fresh_pc0", d_pc[0], 32'h400);
    chk("rstpop_fresh_rclk", 32'(InstrQueueRCLK), 32'd1);

    // PC wrap
    emp = 4'hF;
    step();
    step();
    bo[0] = {32'h0, 32'hE000_0001};
    emp = 4'b1110;
    step();
    chk("wrap_pc0", d_pc[0], 32'hFFFF_FFFC);
    chk("wrap_instr0", d_instr[0], 32'hE000_0001);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       emp = 4'h0;
        1:       emp = 4'hF;
        default: emp = 4'($urandom);
      endcase
      for (int k = 0; k < 4; k++) bo[k] = {$urandom, $urandom};
      DecReady = ($urandom_range(0, 3) != 0);
      Flush    = ($urandom_range(0, 31) == 0);
      step();
    end
    Flush = 0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_dequeue.md
INSTR_DEQUEUE -- requirements
Module: instr_dequeue

Interface
REQ-001 Parameter SLOTS, default 4, meaning number of queue read ports and dispatch lanes; 4 is the only supported value.
REQ-002 CLK  input  1  system clock; all state updates on posedge CLK.
REQ-003 Reset  input  1  asynchronous active-low reset.
REQ-004 InstrQueueBufOut0..3  input  64 each  queue head entries; [63:32] next-PC (PC+4), [31:0] instruction.
REQ-005 InstrQueueBufEmpty0..3  input  1 each  high when the matching head slot holds no entry.
REQ-006 Flush  input  1  Branch or Jump redirect; queue contents invalid.
REQ-007 InstrQueueRE  output  2  pop count minus one (0 to 3 means 1 to 4 entries).
REQ-008 InstrQueueRCLK  output  1  one-cycle pop strobe; the queue consumes RE+1 entries on its rising edge.
REQ-009 DecValid  output  1  dispatch bundle valid.
REQ-010 DecReady  input  1  decode stage accepts the bundle.
REQ-011 DecSlotValid  output  4  per-lane valid, contiguous from lane 0.
REQ-012 DecInstr0..3 / DecPC0..3  output  32 each  instruction and its own PC.

Function
REQ-013 Available count n is the number of contiguous non-empty slots starting at slot 0; a gap ends the count.
REQ-014 States: EMPTY (no bundle held), HOLD (bundle held, DecValid=1), POP (RCLK high, queue advancing), FLUSH.
REQ-015 Capture occurs in EMPTY, or in HOLD with DecReady=1, when n>0, RCLK=0, and Flush=0.
REQ-016 On capture, lanes 0..n-1 load from slots 0..n-1, DecPCk = BufOutk[63:32]-4 (modulo 2^32), DecSlotValid = (1<<n)-1, RE = n-1 registered, RCLK=1 next cycle, next state POP.
REQ-017 POP lasts exactly one cycle: no capture, RCLK returns to 0, DecValid held; next state HOLD. Maximum throughput is 4 instructions per 2 cycles.
REQ-018 In HOLD, DecReady=1 with no capture leads to EMPTY with DecValid=0; DecReady=0 holds all outputs stable.
REQ-019 A bundle is dispatched exactly once, in the cycle with DecValid=1 and DecReady=1.
REQ-020 Flush=1 in any state: next cycle DecValid=0, DecSlotValid=0, RCLK=0, state FLUSH; a held bundle is discarded even if DecReady=1 in the same cycle.
REQ-021 FLUSH stays while Flush=1 and goes to EMPTY one cycle after Flush falls, so heads written by the redirect settle first.
REQ-022 A Flush arriving while RCLK=1 still lets the pop complete; the queue flush takes precedence in the queue.
REQ-023 Empty inputs that are X are treated as empty.

Reset
REQ-024 Reset low: state EMPTY; DecValid, DecSlotValid, InstrQueueRE, InstrQueueRCLK, DecInstr*, and DecPC* all 0, immediately and asynchronously.
REQ-025 Reset asserted during POP aborts the strobe at once; no partial pop is replayed after release.

Configuration
REQ-026 Macro INSTR_DEQUEUE_STATS_EN defined: adds outputs StallCycles[31:0] and DispatchCount[31:0].
REQ-027 StallCycles counts cycles with DecValid=1 and DecReady=0; DispatchCount adds popcount(DecSlotValid) per dispatch; both saturate at all-ones and clear on Reset and on Flush-free reset only.
REQ-028 Macro undefined: no counters, no extra ports, identical timing.

Structure
REQ-029 Shared package dispatch_pkg holds SLOTS, ENTRY_W=64, the PC field offsets, the state enum, and the PC_STEP=4 constant.
REQ-030 Sub-module instr_slot_count computes n and the (1<<n)-1 mask from the four Empty bits combinationally.

Verification
REQ-031 Empty=4'b0000, heads PC fields 0x104/0x108/0x10C/0x110, DecReady=1 -> RE=3, one RCLK pulse, DecPC0..3=0x100..0x10C, DecSlotValid=4'hF.
REQ-032 Empty=4'b1010 (slot 1 empty) -> n=1, RE=0, DecSlotValid=4'b0001.
REQ-033 DecReady=0 for 5 cycles with a bundle held -> outputs stable, no RCLK, StallCycles=5 with the macro defined.
REQ-034 Flush pulsed 1 cycle during HOLD with DecReady=1 -> no dispatch counted, DecValid=0 for 2 cycles, then recapture of new heads.
REQ-035 Reset driven low during POP -> RCLK=0 and DecValid=0 within the same cycle; after release, first capture only on fresh heads.
REQ-036 PC field 0x00000000 -> DecPC0=0xFFFFFFFC (wrap).
